// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions.
// Holds the mode constants used by both the sync generators and the
// receive-side detector, plus the detector FSM state encoding.
package vga_timing_pkg;

   localparam int          COUNTER_SIZE    = 11;
   localparam logic [10:0] WHOLE_LINE      = 11'd1056;
   localparam logic [10:0] THRESHOLD_HSYNC = 11'd128;
   localparam logic [10:0] WHOLE_FRAME     = 11'd628;
   localparam logic [10:0] THRESHOLD_VSYNC = 11'd4;
   localparam int          LOCK_FRAMES     = 3;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } det_state_e;

endpackage

// File: rtl/vga_sync_timing_detector_if.sv
// Sync timing detector bus.
// master: drives h_sync_in/v_sync_in, observes lock status and measurements.
// slave : the detector; samples the syncs, reports locked, frame_start,
//         h/v period and width, raster position and timeout.
interface vga_sync_timing_detector_if #(
   parameter int COUNTER_SIZE = 11
);
   logic                    h_sync_in;
   logic                    v_sync_in;
   logic                    locked;
   logic                    frame_start;
   logic [COUNTER_SIZE-1:0] h_period;
   logic [COUNTER_SIZE-1:0] h_width;
   logic [COUNTER_SIZE-1:0] v_period;
   logic [COUNTER_SIZE-1:0] v_width;
   logic [COUNTER_SIZE-1:0] x_pos;
   logic [COUNTER_SIZE-1:0] y_pos;
   logic                    timeout;

   modport master (
      output h_sync_in, v_sync_in,
      input  locked, frame_start, h_period, h_width, v_period, v_width,
             x_pos, y_pos, timeout
   );

   modport slave (
      input  h_sync_in, v_sync_in,
      output locked, frame_start, h_period, h_width, v_period, v_width,
             x_pos, y_pos, timeout
   );
endinterface

// File: rtl/sync_edge_detector.sv
// Two-flop synchronizer plus delay flop for one sync input.
// Ports: control_clock, reset (sync, active-high), sync_i (async pin),
//        rise_o / fall_o (one-cycle pulses, valid 3 clocks after the pin edge).
module sync_edge_detector (
   input  logic control_clock,
   input  logic reset,
   input  logic sync_i,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic dly_q;

   always_ff @(posedge control_clock) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         dly_q  <= 1'b0;
      end else begin
         meta_q <= sync_i;
         sync_q <= meta_q;
         dly_q  <= sync_q;
      end
   end

   assign rise_o = sync_q & ~dly_q;
   assign fall_o = ~sync_q & dly_q;

endmodule

// File: rtl/vga_sync_timing_detector.sv
// Receive-side VGA sync timing detector.
// Measures line period / h pulse width (clocks) and frame period / v pulse
// width (lines), tracks raster position, and declares lock after
// LOCK_FRAMES consecutive frames that match the expected mode.
// Ports: control_clock, reset (sync, active-high), bus (slave modport):
//        h_sync_in/v_sync_in in; locked, frame_start, h_period, h_width,
//        v_period, v_width, x_pos, y_pos, timeout out.
//
// state     | meaning
// ----------+------------------------------------------------------
// ST_SEARCH | no qualified frame yet, waiting for a matching frame
// ST_VERIFY | match_cnt consecutive matching frames seen
// ST_LOCKED | mode confirmed, stays until a bad frame or timeout
module vga_sync_timing_detector #(
   parameter int                     COUNTER_SIZE    = 11,
   parameter logic [COUNTER_SIZE-1:0] THRESHOLD_HSYNC = vga_timing_pkg::THRESHOLD_HSYNC,
   parameter logic [COUNTER_SIZE-1:0] WHOLE_LINE      = vga_timing_pkg::WHOLE_LINE,
   parameter logic [COUNTER_SIZE-1:0] THRESHOLD_VSYNC = vga_timing_pkg::THRESHOLD_VSYNC,
   parameter logic [COUNTER_SIZE-1:0] WHOLE_FRAME     = vga_timing_pkg::WHOLE_FRAME,
   parameter int                     LOCK_FRAMES     = vga_timing_pkg::LOCK_FRAMES
) (
   input logic                       control_clock,
   input logic                       reset,
   vga_sync_timing_detector_if.slave bus
);
   import vga_timing_pkg::*;

   localparam int                     CS       = COUNTER_SIZE;
   localparam logic [CS-1:0]          CNT_MAX  = '1;
   localparam logic [CS-1:0]          CNT_PRE  = CNT_MAX - CS'(1);
   localparam logic [CS-1:0]          ONE      = CS'(1);
   localparam logic [3:0]             LOCK_CNT = 4'(LOCK_FRAMES);

   logic h_rise, h_fall, v_rise, v_fall;

   logic [CS-1:0] x_pos_q, x_pos_d, y_pos_q, y_pos_d;
   logic [CS-1:0] h_period_q, h_period_d, h_width_q, h_width_d;
   logic [CS-1:0] v_period_q, v_period_d, v_width_q, v_width_d;
   logic [CS-1:0] line_inc;
   logic          timeout_q, timeout_d, line_err_q, line_err_d;
   logic          meas_valid_q, meas_valid_d, frame_start_q;
   logic          h_sat, tmo_evt, frame_ok;
   logic [3:0]    match_cnt_q, match_cnt_d, cnt_inc;
   det_state_e    state_q, state_d;

   sync_edge_detector u_h_edge (
      .control_clock (control_clock),
      .reset         (reset),
      .sync_i        (bus.h_sync_in),
      .rise_o        (h_rise),
      .fall_o        (h_fall)
   );

   sync_edge_detector u_v_edge (
      .control_clock (control_clock),
      .reset         (reset),
      .sync_i        (bus.v_sync_in),
      .rise_o        (v_rise),
      .fall_o        (v_fall)
   );

   always_comb begin
      h_sat    = (x_pos_q == CNT_MAX);
      // Fires on the clock that pushes x_pos into saturation.
      tmo_evt  = (x_pos_q == CNT_PRE) && !h_rise;
      line_inc = {{(CS-1){1'b0}}, h_rise};

      x_pos_d = x_pos_q;
      if (h_rise)      x_pos_d = '0;
      else if (!h_sat) x_pos_d = x_pos_q + ONE;

      timeout_d = timeout_q;
      if (h_rise)       timeout_d = 1'b0;
      else if (tmo_evt) timeout_d = 1'b1;

      // A saturated count is not a real measurement.
      h_period_d = h_period_q;
      if (h_rise && !h_sat) h_period_d = x_pos_q + ONE;
      h_width_d = h_width_q;
      if (h_fall && !h_sat) h_width_d = x_pos_q + ONE;

      y_pos_d = y_pos_q;
      if (v_rise)                             y_pos_d = '0;
      else if (h_rise && (y_pos_q != CNT_MAX)) y_pos_d = y_pos_q + ONE;

      // The coincident h_rise closes the last line of the frame.
      v_period_d = v_period_q;
      if (v_rise) v_period_d = y_pos_q + line_inc;
      v_width_d = v_width_q;
      if (v_fall) v_width_d = y_pos_q + line_inc;

      line_err_d = line_err_q;
      if ((h_rise && !h_sat && (h_period_d != WHOLE_LINE)) ||
          (h_fall && !h_sat && (h_width_d != THRESHOLD_HSYNC)))
         line_err_d = 1'b1;
      if (v_rise) line_err_d = 1'b0;

      meas_valid_d = meas_valid_q;
      if (tmo_evt)     meas_valid_d = 1'b0;
      else if (v_rise) meas_valid_d = 1'b1;

      frame_ok = meas_valid_q && !line_err_q &&
                 (v_period_d == WHOLE_FRAME) && (v_width_q == THRESHOLD_VSYNC) &&
                 (h_period_d == WHOLE_LINE) && (h_width_d == THRESHOLD_HSYNC);
   end

   always_ff @(posedge control_clock) begin
      if (reset) begin
         x_pos_q       <= '0;
         y_pos_q       <= '0;
         h_period_q    <= '0;
         h_width_q     <= '0;
         v_period_q    <= '0;
         v_width_q     <= '0;
         timeout_q     <= 1'b0;
         line_err_q    <= 1'b0;
         meas_valid_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         x_pos_q       <= x_pos_d;
         y_pos_q       <= y_pos_d;
         h_period_q    <= h_period_d;
         h_width_q     <= h_width_d;
         v_period_q    <= v_period_d;
         v_width_q     <= v_width_d;
         timeout_q     <= timeout_d;
         line_err_q    <= line_err_d;
         meas_valid_q  <= meas_valid_d;
         frame_start_q <= v_rise;
      end
   end

   always_ff @(posedge control_clock) begin
      if (reset) begin
         state_q     <= ST_SEARCH;
         match_cnt_q <= 4'd0;
      end else begin
         state_q     <= state_d;
         match_cnt_q <= match_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      match_cnt_d = match_cnt_q;
      cnt_inc     = (state_q == ST_SEARCH) ? 4'd1 : (match_cnt_q + 4'd1);
      if (tmo_evt) begin
         state_d     = ST_SEARCH;
         match_cnt_d = 4'd0;
      end else if (v_rise) begin
         if (!frame_ok) begin
            state_d     = ST_SEARCH;
            match_cnt_d = 4'd0;
         end else if (state_q != ST_LOCKED) begin
            match_cnt_d = cnt_inc;
            state_d     = (cnt_inc == LOCK_CNT) ? ST_LOCKED : ST_VERIFY;
         end
      end
   end

   always_comb begin
      bus.locked = (state_q == ST_LOCKED);
   end

   assign bus.frame_start = frame_start_q;
   assign bus.h_period    = h_period_q;
   assign bus.h_width     = h_width_q;
   assign bus.v_period    = v_period_q;
   assign bus.v_width     = v_width_q;
   assign bus.x_pos       = x_pos_q;
   assign bus.y_pos       = y_pos_q;
   assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_vga_sync_timing_detector.sv
`timescale 1ns/1ps
module tb_vga_sync_timing_detector;

   localparam int CS   = 11;
   localparam int WL   = 24;
   localparam int THS  = 4;
   localparam int WF   = 8;
   localparam int TVS  = 2;
   localparam int LOCK = 3;

   logic control_clock = 1'b0;
   logic reset         = 1'b1;

   vga_sync_timing_detector_if #(.COUNTER_SIZE(CS)) vif ();

   vga_sync_timing_detector #(
      .COUNTER_SIZE    (CS),
      .THRESHOLD_HSYNC (11'(THS)),
      .WHOLE_LINE      (11'(WL)),
      .THRESHOLD_VSYNC (11'(TVS)),
      .WHOLE_FRAME     (11'(WF)),
      .LOCK_FRAMES     (LOCK)
   ) dut (
      .control_clock (control_clock),
      .reset         (reset),
      .bus           (vif)
   );

   always #5 control_clock = ~control_clock;

   int total = 0;
   int bad   = 0;

   // Frame-level reference: a frame is good when every line and the frame
   // itself match the mode; lock holds once LOCK consecutive evaluated frames
   // were good. The frame opened right after reset/timeout is never evaluated.
   int run        = 0;
   bit have_prev  = 0;
   bit prev_good  = 0;
   int prev_lines = 0;
   int prev_vw    = 0;
   int last_per   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic drive_frame(input int nlines, input int vw, input int bad_ln,
                              input int bad_per, input int bad_hw);
      int per, hw;
      bit good, lock_before;
      lock_before = (run >= LOCK);
      if (have_prev) run = prev_good ? run + 1 : 0;
      good = (nlines == WF) && (vw == TVS);
      for (int ln = 0; ln < nlines; ln++) begin
         per = (ln == bad_ln) ? bad_per : WL;
         hw  = (ln == bad_ln) ? bad_hw  : THS;
         if (per != WL || hw != THS) good = 0;
         vif.h_sync_in = 1'b1;
         vif.v_sync_in = (ln < vw);
         for (int c = 1; c <= per; c++) begin
            @(negedge control_clock);
            if (ln == 0 && c == 2) begin
               check_val("frame_start_early", vif.frame_start, 0);
               check_val("locked_before_vrise", vif.locked, lock_before);
            end
            if (c == 3) begin
               check_val("y_pos", vif.y_pos, ln);
               check_val("x_pos_at_rise", vif.x_pos, 0);
               check_val("timeout_clear", vif.timeout, 0);
               check_val("frame_start", vif.frame_start, ln == 0);
               if (ln == 0) begin
                  check_val("locked", vif.locked, run >= LOCK);
                  if (have_prev) begin
                     check_val("v_period", vif.v_period, prev_lines);
                     check_val("v_width", vif.v_width, prev_vw);
                     check_val("h_period", vif.h_period, last_per);
                  end
               end
            end
            if (ln == 0 && c == 4) check_val("frame_start_late", vif.frame_start, 0);
            if (c == per) begin
               check_val("x_pos_eol", vif.x_pos, per - 3);
               check_val("h_width", vif.h_width, hw);
            end
            if (c == hw) vif.h_sync_in = 1'b0;
         end
         last_per = per;
      end
      have_prev  = 1;
      prev_good  = good;
      prev_lines = nlines;
      prev_vw    = vw;
   endtask

   task automatic nominal_frame();
      drive_frame(WF, TVS, -1, WL, THS);
   endtask

   task automatic drive_timeout();
      vif.v_sync_in = 1'b0;
      vif.h_sync_in = 1'b1;
      for (int c = 1; c <= 2100; c++) begin
         @(negedge control_clock);
         if (c == THS) vif.h_sync_in = 1'b0;
         if (c == 2049) check_val("timeout_not_yet", vif.timeout, 0);
         if (c == 2050) begin
            check_val("timeout_set", vif.timeout, 1);
            check_val("locked_on_timeout", vif.locked, 0);
            check_val("x_pos_saturated", vif.x_pos, 2047);
         end
         if (c == 2100) begin
            check_val("x_pos_hold", vif.x_pos, 2047);
            check_val("timeout_sticky", vif.timeout, 1);
            check_val("h_period_kept", vif.h_period, last_per);
         end
      end
      run       = 0;
      have_prev = 0;
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_locked"}, vif.locked, 0);
      check_val({tag, "_frame_start"}, vif.frame_start, 0);
      check_val({tag, "_h_period"}, vif.h_period, 0);
      check_val({tag, "_h_width"}, vif.h_width, 0);
      check_val({tag, "_v_period"}, vif.v_period, 0);
      check_val({tag, "_v_width"}, vif.v_width, 0);
      check_val({tag, "_x_pos"}, vif.x_pos, 0);
      check_val({tag, "_y_pos"}, vif.y_pos, 0);
      check_val({tag, "_timeout"}, vif.timeout, 0);
   endtask

   task automatic mid_frame_reset();
      vif.h_sync_in = 1'b1;
      vif.v_sync_in = 1'b1;
      repeat (10) @(negedge control_clock);
      check_val("locked_before_reset", vif.locked, 1);
      reset = 1'b1;
      vif.h_sync_in = 1'b0;
      vif.v_sync_in = 1'b0;
      @(negedge control_clock);
      check_all_zero("mid_reset");
      @(negedge control_clock);
      reset     = 1'b0;
      run       = 0;
      have_prev = 0;
   endtask

   task automatic random_frame();
      int kind, nl, vw, bl, bp, bh;
      kind = int'($urandom_range(0, 7));
      nl = WF;
      vw = TVS;
      bl = -1;
      bp = WL;
      bh = THS;
      case (kind)
         4: begin
            bl = int'($urandom_range(0, WF - 1));
            bp = WL + (($urandom_range(0, 1) != 0) ? 1 : -1);
         end
         5: begin
            bl = int'($urandom_range(0, WF - 1));
            bh = THS + (($urandom_range(0, 1) != 0) ? 1 : -1);
         end
         6: nl = WF + (($urandom_range(0, 1) != 0) ? 1 : -1);
         7: vw = TVS + (($urandom_range(0, 1) != 0) ? 1 : -1);
         default: ;
      endcase
      drive_frame(nl, vw, bl, bp, bh);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vif.h_sync_in = 1'b0;
      vif.v_sync_in = 1'b0;
      repeat (3) @(negedge control_clock);
      check_all_zero("reset");
      reset = 1'b0;

      repeat (5) nominal_frame();
      drive_frame(WF, TVS, 3, WL - 1, THS);
      repeat (5) nominal_frame();
      drive_timeout();
      repeat (5) nominal_frame();
      drive_frame(WF, TVS + 1, -1, WL, THS);
      repeat (5) nominal_frame();
      mid_frame_reset();
      repeat (5) nominal_frame();
      repeat (30) random_frame();
      nominal_frame();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vga_sync_timing_detector.md
Name: vga_sync_timing_detector

Overview:
- Receive-side counterpart of the VGA sync generators. It samples incoming h_sync/v_sync, measures line period, line pulse width, frame length and frame pulse width, and checks them against the expected mode.
- Declares lock after a run of consecutive matching frames, and reports raster position.
- Sits on the capture/monitor path, ahead of any pixel sampling logic. It is also the self-check for our own controller in loopback.

Parameters:
- THRESHOLD_HSYNC, 11'd128, expected h_sync pulse width in clocks
- WHOLE_LINE, 11'd1056, expected clocks per line (rise to rise)
- THRESHOLD_VSYNC, 11'd4, expected v_sync pulse width in lines
- WHOLE_FRAME, 11'd628, expected lines per frame (rise to rise)
- COUNTER_SIZE, 11, width of all counters and measurements
- LOCK_FRAMES, 3, consecutive matching frames required for lock (1..15)

Ports:
- control_clock  in  1  sole clock
- reset  in  1  synchronous, active-high reset
- h_sync_in  in  1  incoming line sync, active-high pulse
- v_sync_in  in  1  incoming frame sync, active-high pulse
- locked  out  1  mode matched for LOCK_FRAMES consecutive frames
- frame_start  out  1  one-cycle pulse on each detected v_sync rise
- h_period  out  COUNTER_SIZE  last measured clocks per line
- h_width  out  COUNTER_SIZE  last measured h pulse clocks
- v_period  out  COUNTER_SIZE  last measured lines per frame
- v_width  out  COUNTER_SIZE  last measured v pulse lines
- x_pos  out  COUNTER_SIZE  clocks since last h rise
- y_pos  out  COUNTER_SIZE  lines since last v rise
- timeout  out  1  no h rise for 2^COUNTER_SIZE-1 clocks (sticky until next h rise)

Behaviour:
- Reset: every output, counter and measurement is 0; FSM goes to SEARCH; synchronizer flops are 0. All reset logic is synchronous on control_clock, active-high.
- Input stage:
  - 2-flop synchronizer per sync input, then a delay flop for edge detect.
  - h_rise, h_fall, v_rise and v_fall are each valid 3 clocks after the input pin edge.
- Horizontal:
  - x_pos clears to 0 in the h_rise cycle and otherwise increments.
  - On h_rise: h_period <= x_pos+1.
  - On h_fall: h_width <= x_pos+1.
  - x_pos saturates at all-ones and asserts timeout. The saturated value is never latched as a period; the FSM drops to SEARCH.
- Vertical (counted in lines):
  - y_pos increments on each h_rise and clears on v_rise.
  - On v_rise: v_period <= y_pos, plus 1 if h_rise occurs in the same cycle.
  - On v_fall: v_width <= y_pos, with the same +1 rule for a coincident h_rise.
  - A coincident h_rise and v_rise leaves y_pos=0 and x_pos=0.
- line_err:
  - Internal sticky flag, set on any h_rise whose measured period != WHOLE_LINE, or any h_fall whose width != THRESHOLD_HSYNC.
  - Cleared on v_rise, after that v_rise's evaluation has used it.
- frame_ok, evaluated at v_rise, requires all of:
  - meas_valid
  - !line_err
  - the new v_period == WHOLE_FRAME
  - v_width == THRESHOLD_VSYNC
  - the latest h_period/h_width match
- meas_valid: set at the first v_rise after reset or after a timeout. That first partial frame is never evaluated.
- FSM: SEARCH, VERIFY, LOCKED. match_cnt is 4 bits.
  - SEARCH: at v_rise with meas_valid already set -> VERIFY, with match_cnt=1 if frame_ok, else stay in SEARCH.
  - VERIFY:
    - v_rise with frame_ok -> match_cnt+1.
    - When match_cnt reaches LOCK_FRAMES -> LOCKED.
    - v_rise with !frame_ok -> SEARCH, match_cnt=0.
  - LOCKED: any v_rise with !frame_ok, or timeout -> SEARCH immediately, with locked deasserted the next cycle.
  - Timeout in any state -> SEARCH, meas_valid=0, match_cnt=0.
- locked: registered, high only in LOCKED. It rises 1 clock after the qualifying v_rise.
- frame_start: registered copy of v_rise (1 clock latency); pulses in every state.
- Reset asserted mid-frame: everything clears, and lock takes at least LOCK_FRAMES+1 full frames after release.

Decomposition:
- Shared package vga_timing_pkg holds:
  - mode constants (WHOLE_LINE, THRESHOLD_HSYNC, WHOLE_FRAME, THRESHOLD_VSYNC) shared with the generators
  - the FSM state encoding
- One natural sub-module: sync_edge_detector, holding the 2-flop synchronizer plus rise/fall pulses. It is instantiated twice (h and v).

Test Plan:
- Nominal mode (1056/128 clocks, 628/4 lines) from reset -> locked rises 1 clock after the 4th v_rise (1 invalid frame + 3 matching); h_period=1056, h_width=128, v_period=628, v_width=4.
- While locked, one line of 1055 clocks -> line_err set; at the next v_rise locked drops 1 clock later; re-lock after 3 further good frames.
- While locked, h_sync held low for 2047 clocks -> timeout=1, locked=0, x_pos holds 2047; the next h_rise clears timeout.
- Coincident h and v rising edges on the same clock -> v_period=628 (not 627), y_pos=0, x_pos=0, frame_start pulses once.
- Frame with v pulse of 5 lines, all else nominal -> v_width=5, no lock progress (match_cnt 0, state SEARCH).
- Reset asserted mid-frame while LOCKED -> all outputs 0 next clock; after release, lock returns only after 4 v_rises.
